regfile_wport_arb: RTL and testbench
====================================

Name: regfile_wport_arb

Overview:
- Shares the register file's single write port (wreg/wsel/wdata) between two writeback requesters: A (ALU writeback) and B (load/multi-word writeback).
- Round-robin arbitration, with burst locking so a multi-beat writeback (e.g. load-multiple) completes without interleaving.
- Drives the register file write port from registered outputs, one cycle after acceptance.

Parameters:
- AWIDTH, 4, register select width; must match the register file.
- DWIDTH, 16, data width; must match the register file.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a beat.
- a_ready  out  1  requester A beat accepted this cycle when a_valid=1.
- a_wsel  in  AWIDTH  requester A target register.
- a_wdata  in  DWIDTH  requester A write data.
- a_last  in  1  final beat of A's transfer; 1 for single writes.
- b_valid  in  1  requester B has a beat.
- b_ready  out  1  requester B accept.
- b_wsel  in  AWIDTH  requester B target register.
- b_wdata  in  DWIDTH  requester B write data.
- b_last  in  1  final beat of B's transfer.
- wreg  out  1  register file write enable.
- wsel  out  AWIDTH  register file write select.
- wdata  out  DWIDTH  register file write data.
- owner  out  2  debug: 00 IDLE, 01 LOCK_A, 10 LOCK_B.

Behaviour:
- Reset: async on rst_n low.
  - State=IDLE; rr pointer prefers A.
  - wreg=0, wsel=0, wdata=0, owner=00.
  - a_ready/b_ready are combinational and read 0 while rst_n is low.
- Handshake:
  - A beat transfers when x_valid & x_ready at a clock edge.
  - x_ready never depends on x_valid (no combinational valid-to-ready loop).
  - The requester holds wsel/wdata/last stable while valid and not ready.
- States and ready:
  - IDLE: a_ready = !b_valid | prefA; b_ready = !a_valid | !prefA. Never both 1 while both valids are 1.
  - LOCK_A: a_ready=1, b_ready=0.
  - LOCK_B: b_ready=1, a_ready=0.
- Transitions:
  - IDLE, transfer with last=1 -> stay IDLE; rr pointer flips to prefer the other requester.
  - IDLE, transfer with last=0 -> LOCK_x; pointer unchanged.
  - LOCK_x, transfer with last=1 -> IDLE; pointer flips to prefer the other requester.
  - LOCK_x with x_valid=0: hold the lock indefinitely (no timeout). Bubbles inside a burst are legal.
- Pointer is updated only on last-beat transfers. Single-requester traffic flows back-to-back, one beat per cycle.
- Output stage, latency 1:
  - Cycle after a transfer: wreg=1, wsel/wdata = accepted beat.
  - Cycle with no transfer: wreg=0; wsel/wdata hold their previous values.
  - Throughput: one write per cycle.
- Ordering: beats from a single requester reach the register file in acceptance order. With no same-cycle dual grant, write order to a shared register is exactly the grant order.
- Reset mid-burst: lock is dropped, state returns to IDLE, and any beat in the output register is discarded (wreg=0). Requesters must restart their transfers.

Optional Feature:
- Macro: REGFILE_ARB_ZERO_REG_EN.
- Defined: a beat with wsel==0 is still accepted normally and still advances state and pointer. Its output-cycle wreg is forced to 0, so R0 is never written and reads as hardwired zero provided it was zeroed at init.
- Undefined: register 0 is written like any other register.

Test Plan:
- Reset: hold rst_n=0 with a_valid=b_valid=1 -> a_ready=b_ready=0, wreg=0, owner=00. Release -> A granted first (prefA).
- Round-robin: both valid, all last=1, 4 beats each, A wsel 1..4 and B wsel 9..12 -> wsel sequence 1,9,2,10,3,11,4,12 with wreg=1 every cycle, one cycle behind acceptance.
- Burst lock: B starts 3-beat burst (wsel 5,6,7, data 0x1111/0x2222/0x3333, last on 3rd) while A valid throughout -> a_ready=0 for 3 beats, owner=10. A's write (wsel 2, 0xBEEF) appears the cycle after B's last beat reaches the port.
- Burst bubble: A burst of 2 with a_valid=0 for 3 cycles between beats, b_valid=1 throughout -> b_ready stays 0, wreg=0 during the bubble, owner=01 until A's last beat.
- Reset mid-burst: assert rst_n low after beat 1 of a 3-beat B burst -> owner=00 and wreg=0 immediately. After release with both valid, A is granted.
- REGFILE_ARB_ZERO_REG_EN: A writes wsel=0 data 0xFFFF then wsel=3 data 0x0042 -> with macro: one wreg pulse (wsel 3). Without macro: two wreg pulses.

Source files
------------

// File: rtl/regfile_wport_arb.sv
// Round-robin, burst-locking arbiter for the single register file write port.
// Optional REGFILE_ARB_ZERO_REG_EN suppresses writes that target register 0.
module regfile_wport_arb #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AWIDTH-1:0] a_wsel,
  input  logic [DWIDTH-1:0] a_wdata,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AWIDTH-1:0] b_wsel,
  input  logic [DWIDTH-1:0] b_wdata,
  input  logic              b_last,
  output logic              wreg,
  output logic [AWIDTH-1:0] wsel,
  output logic [DWIDTH-1:0] wdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOCK_A = 2'b01,
    LOCK_B = 2'b10
  } state_t;

  state_t state, state_nx;
  logic   pref_a;

  logic              a_fire, b_fire, fire;
  logic              beat_last, beat_keep;
  logic [AWIDTH-1:0] beat_sel;
  logic [DWIDTH-1:0] beat_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pref_a <= 1'b1;
    end else begin
      state <= state_nx;
      if (fire && beat_last)
        pref_a <= b_fire;
    end
  end

  always_comb begin
    state_nx = state;
    if (fire) begin
      if (beat_last)
        state_nx = IDLE;
      else if (state == IDLE)
        state_nx = a_fire ? LOCK_A : LOCK_B;
    end
  end

  // Ready is a function of state and the other side's valid only.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          a_ready = !b_valid || pref_a;
          b_ready = !a_valid || !pref_a;
        end
        LOCK_A:  a_ready = 1'b1;
        LOCK_B:  b_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign owner  = state;
  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;
  assign fire   = a_fire || b_fire;

  assign beat_last = a_fire ? a_last  : b_last;
  assign beat_sel  = a_fire ? a_wsel  : b_wsel;
  assign beat_data = a_fire ? a_wdata : b_wdata;

`ifdef REGFILE_ARB_ZERO_REG_EN
  assign beat_keep = (beat_sel != '0);
`else
  assign beat_keep = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wreg  <= 1'b0;
      wsel  <= '0;
      wdata <= '0;
    end else begin
      wreg <= fire && beat_keep;
      if (fire) begin
        wsel  <= beat_sel;
        wdata <= beat_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Randomized bench for regfile_wport_arb against a transaction-level model.
// Honours REGFILE_ARB_ZERO_REG_EN when the same macro is defined.
module tb_regfile_wport_arb;

  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid, a_ready, a_last;
  logic [AW-1:0] a_wsel;
  logic [DW-1:0] a_wdata;
  logic          b_valid, b_ready, b_last;
  logic [AW-1:0] b_wsel;
  logic [DW-1:0] b_wdata;
  logic          wreg;
  logic [AW-1:0] wsel;
  logic [DW-1:0] wdata;
  logic [1:0]    owner;

  regfile_wport_arb #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_wsel(a_wsel),
    .a_wdata(a_wdata), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_wsel(b_wsel),
    .b_wdata(b_wdata), .b_last(b_last),
    .wreg(wreg), .wsel(wsel), .wdata(wdata), .owner(owner)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Requester stimulus: pending beat and beats left in the transfer.
  logic          rv [2];
  logic [AW-1:0] rs [2];
  logic [DW-1:0] rd [2];
  int            rem [2];

  // Model: who holds the port, who is preferred, what the port shows.
  int            own;
  bit            pa;
  bit            ew;
  logic [AW-1:0] es;
  logic [DW-1:0] ed;
  bit            era, erb, fa, fb;

  task automatic model_reset();
    own = 0; pa = 1'b1;
    ew = 1'b0; es = '0; ed = '0;
    for (int r = 0; r < 2; r++) begin
      rv[r] = 1'b0; rem[r] = 0; rs[r] = '0; rd[r] = '0;
    end
  endtask

  task automatic gen();
    for (int r = 0; r < 2; r++) begin
      if (!rv[r]) begin
        if (rem[r] == 0 && $urandom_range(0, 3) != 0) begin
          rem[r] = int'($urandom_range(1, 3));
          rv[r]  = 1'b1;
        end else if (rem[r] > 0 && $urandom_range(0, 2) != 0) begin
          rv[r] = 1'b1;
        end
        if (rv[r]) begin
          rs[r] = AW'($urandom_range(0, 15));
          rd[r] = DW'($urandom);
        end
      end
    end
  endtask

  task automatic drive();
    a_valid = rv[0]; a_wsel = rs[0]; a_wdata = rd[0]; a_last = (rem[0] == 1);
    b_valid = rv[1]; b_wsel = rs[1]; b_wdata = rd[1]; b_last = (rem[1] == 1);
  endtask

  task automatic check_cycle();
    if (own == 1) begin era = 1; erb = 0; end
    else if (own == 2) begin era = 0; erb = 1; end
    else begin
      era = !rv[1] || pa;
      erb = !rv[0] || !pa;
    end
    chk("a_ready", 32'(a_ready), 32'(era));
    chk("b_ready", 32'(b_ready), 32'(erb));
    chk("wreg", 32'(wreg), 32'(ew));
    chk("wsel", 32'(wsel), 32'(es));
    chk("wdata", 32'(wdata), 32'(ed));
    chk("owner", 32'(owner), 32'(own));
    fa = rv[0] && era;
    fb = rv[1] && erb;
  endtask

  task automatic model_step();
    int  k;
    bit  last;
    if (fa || fb) begin
      k    = fa ? 0 : 1;
      last = (rem[k] == 1);
`ifdef REGFILE_ARB_ZERO_REG_EN
      ew = (rs[k] != '0);
`else
      ew = 1'b1;
`endif
      es = rs[k]; ed = rd[k];
      if (last) begin
        own = 0;
        pa  = (k == 1);
      end else begin
        own = k + 1;
      end
      rem[k]--;
      rv[k] = 1'b0;
    end else begin
      ew = 1'b0;
    end
  endtask

  bit mid_reset_done = 0;

  initial begin
    model_reset();
    a_valid = 1; a_wsel = 4'd1; a_wdata = 16'h1234; a_last = 1;
    b_valid = 1; b_wsel = 4'd9; b_wdata = 16'h5678; b_last = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_wreg", 32'(wreg), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_wsel", 32'(wsel), 0);
    chk("rst_wdata", 32'(wdata), 0);
    @(negedge clk);
    rst_n = 1;
    drive();

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!mid_reset_done && i > 600 && own != 0) begin
        mid_reset_done = 1;
        rst_n = 0;
        a_valid = 1; b_valid = 1;
        #1;
        chk("mid_rst_owner", 32'(owner), 0);
        chk("mid_rst_wreg", 32'(wreg), 0);
        chk("mid_rst_a_ready", 32'(a_ready), 0);
        chk("mid_rst_b_ready", 32'(b_ready), 0);
        @(negedge clk);
        model_reset();
        rst_n = 1;
        a_valid = 1; a_last = 1; b_valid = 1; b_last = 1;
        #1;
        chk("post_rst_a_ready", 32'(a_ready), 1);
        chk("post_rst_b_ready", 32'(b_ready), 0);
        a_valid = 0; b_valid = 0;
        @(negedge clk);
      end
      gen();
      drive();
      #1;
      check_cycle();
      @(posedge clk);
      model_step();
    end

    if (!mid_reset_done)
      chk("mid_reset_reached", 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
